// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: pops DLEN-bit words from the TX FIFO and sends each one
// as an asynchronous UART frame: start bit, DLEN data bits LSB first, an
// optional parity bit, then STOP_BITS stop bits. Every bit is held for
// CLK_DIV clk cycles.
//
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit after the
// data bits. The parity bit is even when PARITY_ODD=0 and odd when PARITY_ODD=1.
//
// Ports:
//   clk          clock
//   rstn         synchronous active-low reset
//   i_en         transmitter enable, sampled only in IDLE
//   o_txb_ren    TX FIFO read strobe, one-cycle pulse (combinational in IDLE)
//   i_txb_rdata  TX FIFO read data, valid the cycle after o_txb_ren
//   i_txb_empty  TX FIFO empty flag
//   o_txd        serial output line, idle high (registered)
//   o_busy       high whenever the state is not IDLE (registered)
//   o_done       one-cycle pulse on the last cycle of the final stop bit
module uart_tx_serializer #(
  parameter int unsigned DLEN       = 8,
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_en,
  output logic            o_txb_ren,
  input  logic [DLEN-1:0] i_txb_rdata,
  input  logic            i_txb_empty,
  output logic            o_txd,
  output logic            o_busy,
  output logic            o_done
);

  localparam int unsigned BW = $clog2(CLK_DIV);
  localparam int unsigned CW = $clog2(DLEN) + 1;

  // Parameter legality checks
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("uart_tx_serializer: CLK_DIV must be >= 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("uart_tx_serializer: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [CW-1:0]   bit_q, bit_d;
  logic            stop_q, stop_d;
  logic [DLEN-1:0] shift_q, shift_d;
  logic            txd_d, busy_d, done_d;
  logic            bit_tick;
  logic            stop_last;

`ifdef UART_TX_PARITY_EN
  logic            par_q;
`endif

  // FIFO pop request; gated by rstn so no pop is issued while reset is held
  assign o_txb_ren = rstn && (state_q == ST_IDLE) && i_en && !i_txb_empty;

  assign bit_tick  = (baud_q == BW'(CLK_DIV - 1));
  assign stop_last = (stop_q == 1'(STOP_BITS - 1));

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      o_txd   <= 1'b1;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      o_txd   <= txd_d;
      o_busy  <= busy_d;
      o_done  <= done_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity of the word captured in LOAD, already folded with the parity sense
  always_ff @(posedge clk) begin
    if (!rstn) begin
      par_q <= 1'b0;
    end else if (state_q == ST_LOAD) begin
      par_q <= (^i_txb_rdata) ^ 1'(PARITY_ODD);
    end
  end
`endif

  // Next-state, counters and next values of the registered outputs
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    txd_d   = 1'b1;
    busy_d  = 1'b0;

    if (state_q != ST_IDLE && state_q != ST_LOAD) begin
      baud_d = bit_tick ? '0 : baud_q + BW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (o_txb_ren) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        shift_d = i_txb_rdata;
        baud_d  = '0;
        state_d = ST_START;
      end
      ST_START: begin
        if (bit_tick) begin
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == CW'(DLEN - 1)) begin
            stop_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + CW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_tick) begin
          stop_d  = 1'b0;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // o_done is registered, so raise it one cycle ahead of the final tick
        done_d = stop_last && (baud_q == BW'(CLK_DIV - 2));
        if (bit_tick) begin
          if (stop_last) begin
            state_d = ST_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Line level follows the state being entered so o_txd lines up with it
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = par_q;
`endif
      default:   txd_d = 1'b1;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer. Instance u_dut1 uses CLK_DIV=4,
// STOP_BITS=1, PARITY_ODD=0; instance u_dut2 uses CLK_DIV=4, STOP_BITS=2,
// PARITY_ODD=1. Each instance is fed from a small FIFO model.
module tb_uart_tx_serializer;

  localparam int CDIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk;
  logic       rstn;
  logic       en1, en2;
  logic       ren1, ren2;
  logic [7:0] rdata1, rdata2;
  logic       empty1, empty2;
  logic       txd1, txd2, busy1, busy2, done1, done2;

  uart_tx_serializer #(.DLEN(8), .CLK_DIV(CDIV), .STOP_BITS(1), .PARITY_ODD(0)) u_dut1 (
    .clk(clk), .rstn(rstn), .i_en(en1), .o_txb_ren(ren1), .i_txb_rdata(rdata1),
    .i_txb_empty(empty1), .o_txd(txd1), .o_busy(busy1), .o_done(done1)
  );

  uart_tx_serializer #(.DLEN(8), .CLK_DIV(CDIV), .STOP_BITS(2), .PARITY_ODD(1)) u_dut2 (
    .clk(clk), .rstn(rstn), .i_en(en2), .o_txb_ren(ren2), .i_txb_rdata(rdata2),
    .i_txb_empty(empty2), .o_txd(txd2), .o_busy(busy2), .o_done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO models: data appears on rdata the cycle after a read strobe
  logic [7:0] mem1 [0:15];
  logic [7:0] mem2 [0:15];
  int wr1 = 0, rd1 = 0, wr2 = 0, rd2 = 0;
  assign empty1 = (wr1 == rd1);
  assign empty2 = (wr2 == rd2);

  int ren_cnt1 = 0, ren_cnt2 = 0, consec = 0;
  logic prev1 = 1'b0, prev2 = 1'b0;

  always @(posedge clk) begin
    if (ren1) begin
      rdata1   <= mem1[rd1[3:0]];
      rd1      <= rd1 + 1;
      ren_cnt1 <= ren_cnt1 + 1;
    end
    if (ren2) begin
      rdata2   <= mem2[rd2[3:0]];
      rd2      <= rd2 + 1;
      ren_cnt2 <= ren_cnt2 + 1;
    end
    prev1 <= ren1;
    prev2 <= ren2;
    if ((ren1 && prev1) || (ren2 && prev2) || (ren1 && empty1) || (ren2 && empty2))
      consec <= consec + 1;
  end

  // Selected instance for the shared frame checker
  logic sel;
  logic txd_s, busy_s, done_s, ren_s;
  assign txd_s  = sel ? txd2  : txd1;
  assign busy_s = sel ? busy2 : busy1;
  assign done_s = sel ? done2 : done1;
  assign ren_s  = sel ? ren2  : ren1;

  int n_assert = 0;
  int n_fail   = 0;
  int snap;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push1(input logic [7:0] d);
    mem1[wr1[3:0]] = d;
    wr1 = wr1 + 1;
  endtask

  task automatic push2(input logic [7:0] d);
    mem2[wr2[3:0]] = d;
    wr2 = wr2 + 1;
  endtask

  // Wait (bounded) for the selected read strobe, sampled away from posedge
  task automatic wait_ren();
    int k;
    k = 0;
    #1;
    while (!ren_s && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("ren_seen", ren_s, 1'b1);
  endtask

  // Called in the IDLE cycle that issues ren; checks LOAD, the whole frame,
  // and the following IDLE cycle.
  task automatic check_frame(input logic [7:0] b, input int stops, input logic odd,
                             input logic drop);
    int   nb;
    logic exp;
    nb = 1 + 8 + PAR + stops;
    @(negedge clk);
    chk("load_txd", txd_s, 1'b1);
    chk("load_busy", busy_s, 1'b1);
    for (int i = 0; i < nb; i++) begin
      if (i == 0)                   exp = 1'b0;
      else if (i <= 8)              exp = b[i-1];
      else if (PAR == 1 && i == 9)  exp = (^b) ^ odd;
      else                          exp = 1'b1;
      for (int c = 0; c < CDIV; c++) begin
        @(negedge clk);
        chk("frame_txd", txd_s, exp);
        chk("frame_done", done_s, (i == nb - 1 && c == CDIV - 1));
        chk("frame_busy", busy_s, 1'b1);
        if (drop && i == 4 && c == 0) begin
          if (sel) en2 = 1'b0;
          else     en1 = 1'b0;
        end
      end
    end
    @(negedge clk);
    chk("post_busy", busy_s, 1'b0);
    chk("post_txd", txd_s, 1'b1);
    chk("post_done", done_s, 1'b0);
  endtask

  initial begin
    sel  = 1'b0;
    rstn = 1'b0;
    en1  = 1'b1;
    en2  = 1'b0;
    push1(8'hA5);

    // Reset state, with data pending and enable high
    repeat (3) @(negedge clk);
    chk("rst_txd1", txd1, 1'b1);
    chk("rst_busy1", busy1, 1'b0);
    chk("rst_done1", done1, 1'b0);
    chk("rst_ren1", ren1, 1'b0);
    chk("rst_txd2", txd2, 1'b1);
    chk("rst_busy2", busy2, 1'b0);
    rstn = 1'b1;

    // Single frame 0xA5
    snap = ren_cnt1;
    wait_ren();
    check_frame(8'hA5, 1, 1'b0, 1'b0);
    chk_int("single_ren_count", ren_cnt1 - snap, 1);

    // Back-to-back 0x55 then 0x0F: second ren in the first IDLE cycle
    snap = ren_cnt1;
    push1(8'h55);
    push1(8'h0F);
    wait_ren();
    check_frame(8'h55, 1, 1'b0, 1'b0);
    chk("b2b_ren", ren1, 1'b1);
    check_frame(8'h0F, 1, 1'b0, 1'b0);
    chk_int("b2b_ren_count", ren_cnt1 - snap, 2);

    // Empty FIFO, then disabled with data pending
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("empty_ren", ren1, 1'b0);
      chk("empty_txd", txd1, 1'b1);
      chk("empty_busy", busy1, 1'b0);
    end
    en1 = 1'b0;
    push1(8'h13);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("dis_ren", ren1, 1'b0);
      chk("dis_txd", txd1, 1'b1);
      chk("dis_busy", busy1, 1'b0);
    end

    // Reset during data bit 5 of 0x13, then a clean frame 0x6C
    en1 = 1'b1;
    wait_ren();
    repeat (27) @(negedge clk);
    chk("pre_rst_bit5", txd1, 1'b0);
    chk("pre_rst_busy", busy1, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_txd", txd1, 1'b1);
    chk("mid_rst_busy", busy1, 1'b0);
    chk("mid_rst_done", done1, 1'b0);
    chk("mid_rst_ren", ren1, 1'b0);
    rstn = 1'b1;
    push1(8'h6C);
    wait_ren();
    check_frame(8'h6C, 1, 1'b0, 1'b0);

    // Two stop bits with enable dropped during data bit 3
    sel = 1'b1;
    en1 = 1'b0;
    push2(8'h5A);
    push2(8'h77);
    en2 = 1'b1;
    wait_ren();
    check_frame(8'h5A, 2, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("drop_no_ren", ren2, 1'b0);
    end
    chk_int("drop_ren_count", ren_cnt2, 1);
    en2 = 1'b1;
    wait_ren();
    check_frame(8'h77, 2, 1'b1, 1'b0);
    chk_int("final_ren_count2", ren_cnt2, 2);
    chk_int("ren_protocol_violations", consec, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
